life_datapath: RTL and testbench

Datapath stage directly downstream of the user-input control FSM. It owns the 16×16 cell grid, latches X/Y coordinates from the switch bus, and toggles and plots individual cells on `load`. While `start` is high it advances the grid by Conway generations (B3/S23, toroidal) at a divided rate and streams every cell to the VGA plot interface after each generation.

---
 rtl/life_pkg.sv | 26 ++
 rtl/life_next_gen.sv | 42 ++++
 rtl/life_datapath.sv | 159 +++++++++++++++
 tb/tb_life_datapath.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module   : life_pkg
// Brief    : Shared grid geometry, colour codes and FSM state encoding for
//            the Game-of-Life datapath.
// Revision : 1.0 - initial release
// ============================================================================
package life_pkg;

    localparam int GRID_DIM   = 16;
    localparam int COORD_W    = 4;
    localparam int GRID_CELLS = GRID_DIM * GRID_DIM;

    localparam logic [2:0] COL_DEAD = 3'b000;
    localparam logic [2:0] COL_LIVE = 3'b111;
    localparam logic [2:0] COL_BORN = 3'b010;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_PLOT  = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] ST_STEP  = 3'd3;
    localparam logic [STATE_W-1:0] ST_SWEEP = 3'd4;

endpackage
`default_nettype wire

// File: rtl/life_next_gen.sv
`default_nettype none
// ============================================================================
// Module   : life_next_gen
// Brief    : Combinational B3/S23 generation step on a toroidal 16x16 grid.
//            Cell (x,y) lives at bit y*16+x. Optional LIFE_AGE_COLOUR_EN
//            adds a newborn vector output.
// Revision : 1.0 - initial release
// ============================================================================
module life_next_gen
    import life_pkg::*;
(
    input  logic [GRID_CELLS-1:0] grid,
`ifdef LIFE_AGE_COLOUR_EN
    output logic [GRID_CELLS-1:0] born,
`endif
    output logic [GRID_CELLS-1:0] next_grid
);

    for (genvar gy = 0; gy < GRID_DIM; gy++) begin : g_row
        for (genvar gx = 0; gx < GRID_DIM; gx++) begin : g_col
            // Neighbour coordinates wrap modulo the grid dimension.
            localparam int YM = (gy + GRID_DIM - 1) % GRID_DIM;
            localparam int YP = (gy + 1) % GRID_DIM;
            localparam int XM = (gx + GRID_DIM - 1) % GRID_DIM;
            localparam int XP = (gx + 1) % GRID_DIM;

            logic [3:0] w_cnt;
            assign w_cnt = 4'(grid[YM*GRID_DIM + XM]) + 4'(grid[YM*GRID_DIM + gx])
                         + 4'(grid[YM*GRID_DIM + XP]) + 4'(grid[gy*GRID_DIM + XM])
                         + 4'(grid[gy*GRID_DIM + XP]) + 4'(grid[YP*GRID_DIM + XM])
                         + 4'(grid[YP*GRID_DIM + gx]) + 4'(grid[YP*GRID_DIM + XP]);

            assign next_grid[gy*GRID_DIM + gx] = (w_cnt == 4'd3) ||
                                                 (grid[gy*GRID_DIM + gx] && (w_cnt == 4'd2));
`ifdef LIFE_AGE_COLOUR_EN
            assign born[gy*GRID_DIM + gx] = !grid[gy*GRID_DIM + gx] && (w_cnt == 4'd3);
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/life_datapath.sv
`default_nettype none
// ============================================================================
// Module   : life_datapath
// Brief    : Owns the 16x16 life grid, handles cell toggling and timed
//            generation stepping, and streams cells to the VGA plotter.
//            Optional macro LIFE_AGE_COLOUR_EN draws newborn cells in green.
// Revision : 1.0 - initial release
// ============================================================================
module life_datapath
    import life_pkg::*;
#(
    parameter int GEN_DIV = 1_000_000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ldX,
    input  logic                ldY,
    input  logic                load,
    input  logic                start,
    input  logic [7:0]          loadVal,
    output logic [COORD_W-1:0]  plot_x,
    output logic [COORD_W-1:0]  plot_y,
    output logic [2:0]          plot_colour,
    output logic                plot,
    output logic                busy,
    output logic [15:0]         gen_count
);

    localparam int DIV_W = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(GEN_DIV - 1);

    logic [STATE_W-1:0]    r_state;
    logic [COORD_W-1:0]    r_x;
    logic [COORD_W-1:0]    r_y;
    logic [DIV_W-1:0]      r_div;
    logic [7:0]            r_scan;
    logic [GRID_CELLS-1:0] r_grid;
    logic [15:0]           r_gen;
    logic [GRID_CELLS-1:0] w_next;
    logic [7:0]            w_sel;
    logic [7:0]            w_idx;
    logic [2:0]            w_colour;
    logic                  w_unused_hi;

    assign w_unused_hi = ^loadVal[7:4];
    assign w_sel       = {r_y, r_x};

`ifdef LIFE_AGE_COLOUR_EN
    logic [GRID_CELLS-1:0] r_born;
    logic [GRID_CELLS-1:0] w_born;
`endif

    life_next_gen u_next_gen (
        .grid      (r_grid),
`ifdef LIFE_AGE_COLOUR_EN
        .born      (w_born),
`endif
        .next_grid (w_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_div   <= '0;
            r_scan  <= '0;
            r_grid  <= '0;
            r_gen   <= '0;
`ifdef LIFE_AGE_COLOUR_EN
            r_born  <= '0;
`endif
        end else begin
            if (ldX) r_x <= loadVal[3:0];
            if (ldY) r_y <= loadVal[3:0];

            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_grid[w_sel] <= ~r_grid[w_sel];
`ifdef LIFE_AGE_COLOUR_EN
                        r_born[w_sel] <= 1'b0;
`endif
                        r_state <= ST_PLOT;
                    end else if (start) begin
                        r_div   <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_PLOT: r_state <= ST_IDLE;
                ST_WAIT: begin
                    if (!start) begin
                        r_div   <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_div == DIV_LAST) begin
                        r_div   <= '0;
                        r_state <= ST_STEP;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_STEP: begin
                    r_grid  <= w_next;
`ifdef LIFE_AGE_COLOUR_EN
                    r_born  <= w_born;
`endif
                    r_gen   <= r_gen + 16'd1;
                    r_scan  <= '0;
                    r_state <= ST_SWEEP;
                end
                ST_SWEEP: begin
                    // The sweep always runs to completion; start only picks the exit.
                    r_scan <= r_scan + 8'd1;
                    if (r_scan == 8'hFF) r_state <= start ? ST_WAIT : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_idx = (r_state == ST_SWEEP) ? r_scan : w_sel;
        if (!r_grid[w_idx])
            w_colour = COL_DEAD;
`ifdef LIFE_AGE_COLOUR_EN
        else if (r_born[w_idx])
            w_colour = COL_BORN;
`endif
        else
            w_colour = COL_LIVE;
    end

    always_comb begin
        plot        = 1'b0;
        plot_x      = '0;
        plot_y      = '0;
        plot_colour = COL_DEAD;
        case (r_state)
            ST_PLOT: begin
                plot        = 1'b1;
                plot_x      = r_x;
                plot_y      = r_y;
                plot_colour = w_colour;
            end
            ST_SWEEP: begin
                plot        = 1'b1;
                plot_x      = r_scan[3:0];
                plot_y      = r_scan[7:4];
                plot_colour = w_colour;
            end
            default: ;
        endcase
    end

    assign busy      = (r_state != ST_IDLE);
    assign gen_count = r_gen;

endmodule
`default_nettype wire

// File: tb/tb_life_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_datapath
// Brief    : Scoreboard bench for life_datapath with a behavioural grid model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_life_datapath;

    localparam int GEN_DIV = 4;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ldX = 1'b0, ldY = 1'b0, load = 1'b0, start = 1'b0;
    logic [7:0] loadVal = 8'h00;
    logic [3:0] plot_x, plot_y;
    logic [2:0] plot_colour;
    logic       plot, busy;
    logic [15:0] gen_count;

    int total = 0;
    int bad = 0;
    int plots_seen = 0;
    int cyc = 0;
    exp_t exp_q[$];

    bit [255:0] mgrid = '0;
    bit [255:0] mborn = '0;
    int mx = 0, my = 0;
    int exp_gen = 0;

    life_datapath #(.GEN_DIV(GEN_DIV)) dut (
        .clock(clk), .reset(rst_n), .ldX(ldX), .ldY(ldY), .load(load),
        .start(start), .loadVal(loadVal), .plot_x(plot_x), .plot_y(plot_y),
        .plot_colour(plot_colour), .plot(plot), .busy(busy), .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    // Monitor: every plot cycle must match the head of the expected queue.
    always @(negedge clk) begin
        if (plot) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d col=%0d, expected no plot",
                         plot_x, plot_y, plot_colour);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (plot_x !== e.x || plot_y !== e.y || plot_colour !== e.c) begin
                    bad++;
                    $display("FAIL plot_cell: got x=%0d y=%0d col=%0d, expected x=%0d y=%0d col=%0d",
                             plot_x, plot_y, plot_colour, e.x, e.y, e.c);
                end
            end
            plots_seen++;
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    function automatic logic [2:0] mcol(input int i);
        if (!mgrid[i]) return 3'b000;
`ifdef LIFE_AGE_COLOUR_EN
        if (mborn[i]) return 3'b010;
`endif
        return 3'b111;
    endfunction

    function automatic void push(input int x, input int y);
        exp_t e;
        e.x = 4'(x);
        e.y = 4'(y);
        e.c = mcol(y * 16 + x);
        exp_q.push_back(e);
    endfunction

    function automatic void mtoggle(input int x, input int y);
        mgrid[y * 16 + x] = ~mgrid[y * 16 + x];
        mborn[y * 16 + x] = 1'b0;
    endfunction

    function automatic void model_step();
        bit [255:0] ng, nb;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                int c;
                bit alive;
                c = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dy != 0 || dx != 0)
                            c += int'(mgrid[((y + dy + 16) % 16) * 16 + (x + dx + 16) % 16]);
                alive = mgrid[y * 16 + x];
                ng[y * 16 + x] = (c == 3) || (alive && c == 2);
                nb[y * 16 + x] = !alive && (c == 3);
            end
        end
        mgrid = ng;
        mborn = nb;
    endfunction

    task automatic set_xy(input int x, input int y);
        if (x == y) begin
            ldX = 1; ldY = 1; loadVal = {4'($urandom), 4'(x)}; tick();
        end else begin
            ldX = 1; loadVal = {4'($urandom), 4'(x)}; tick();
            ldX = 0; ldY = 1; loadVal = {4'($urandom), 4'(y)}; tick();
        end
        ldX = 0; ldY = 0;
        mx = x; my = y;
    endtask

    task automatic set_cell(input int x, input int y);
        set_xy(x, y);
        mtoggle(x, y);
        push(x, y);
        load = 1; tick();
        load = 0; tick(); tick();
    endtask

    // Runs n generations with start held, dropping start 100 cycles into the last sweep.
    task automatic run_gens(input int n, input bit with_load);
        int target, gc_prev, last_t, t, budget, w;
        bit injected;
        injected = 0;
        if (with_load) begin
            mtoggle(mx, my);
            push(mx, my);
        end
        for (int g = 0; g < n; g++) begin
            model_step();
            for (int i = 0; i < 256; i++) push(i % 16, i / 16);
        end
        exp_gen = (exp_gen + n) & 16'hFFFF;
        target = plots_seen + n * 256 + (with_load ? 1 : 0);
        start = 1; load = with_load; tick(); load = 0;
        gc_prev = int'(gen_count); last_t = -1; t = 0;
        budget = n * (GEN_DIV + 257) + 50;
        while (plots_seen < target && t < budget) begin
            if (!injected && plot && plots_seen == target - 200) begin
                load = 1; injected = 1;
            end else begin
                load = 0;
            end
            if (plots_seen >= target - 156) start = 0;
            tick(); t++;
            if (int'(gen_count) != gc_prev) begin
                if (last_t >= 0) chk("gen_period", t - last_t, GEN_DIV + 257);
                last_t = t;
                gc_prev = int'(gen_count);
            end
        end
        if (t >= budget) chk("run_timeout", t, -1);
        start = 0; load = 0;
        w = 0;
        while (busy && w < 300) begin tick(); w++; end
        chk("busy_after_run", int'(busy), 0);
        chk("sweep_plot_total", plots_seen, target);
        chk("gen_count", int'(gen_count), exp_gen);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        #1 rst_n = 0;
        repeat (3) tick();
        chk("rst_plot", int'(plot), 0);
        chk("rst_plot_x", int'(plot_x), 0);
        chk("rst_plot_y", int'(plot_y), 0);
        chk("rst_colour", int'(plot_colour), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_gen_count", int'(gen_count), 0);
        rst_n = 1;
        tick();

        // Single toggle on and off at (5,3).
        set_cell(5, 3);
        set_cell(5, 3);

        // Blinker.
        set_cell(7, 6);
        set_cell(7, 7);
        set_cell(7, 8);
        run_gens(2, 0);

        // Reset during WAIT_GEN.
        start = 1; tick(); tick();
        chk("busy_in_wait", int'(busy), 1);
        rst_n = 0;
        #1;
        chk("async_rst_plot", int'(plot), 0);
        chk("async_rst_gen", int'(gen_count), 0);
        chk("async_rst_busy", int'(busy), 0);
        mgrid = '0; mborn = '0; mx = 0; my = 0; exp_gen = 0;
        start = 0;
        repeat (3) tick();
        rst_n = 1;
        p = plots_seen;
        repeat (10) tick();
        chk("no_plot_after_reset", plots_seen, p);

        // Glider straddling the wrap corner.
        set_cell(15, 14);
        set_cell(0, 15);
        set_cell(14, 0);
        set_cell(15, 0);
        set_cell(0, 0);
        run_gens(4, 0);

        // Random soup.
        for (int k = 0; k < 40; k++) set_cell($urandom_range(0, 15), $urandom_range(0, 15));
        run_gens(3, 0);

        // load and start together in IDLE.
        set_xy($urandom_range(0, 15), $urandom_range(0, 15));
        run_gens(2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
